// File: rtl/keycode_pkg.sv
// keycode_pkg: HID key codes, key event record and event FSM states shared by keycode_event_decoder
package keycode_pkg;
  localparam logic [7:0] HID_A = 8'h04;
  localparam logic [7:0] HID_D = 8'h07;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  typedef struct packed {
    logic [7:0] code;
    logic       press;
  } key_evt_t;
  typedef enum logic [1:0] {IDLE, EMIT_REL, EMIT_PRESS} evt_state_e;
endpackage

// File: rtl/evt_fifo.sv
// evt_fifo: sync key_evt_t FIFO (clk, active-low sync rst_n, push/din in, pop in, dout/full/empty out); dout reads 0 when empty
module evt_fifo import keycode_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  key_evt_t din,
  output key_evt_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  key_evt_t mem_q [DEPTH];
  always_comb begin
    empty = wr_q == rd_q;
    full = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = wr_q + PW'(do_push);
    rd_d = rd_q + PW'(do_pop);
    dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/keycode_event_decoder.sv
// keycode_event_decoder: debounces the HID keycode into press/release events (valid/ready FIFO), held bits and per-frame latched left/right/fire
module keycode_event_decoder import keycode_pkg::*; #(
  parameter int         STABLE_CYCLES = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] KEY_LEFT = HID_A,
  parameter logic [7:0] KEY_RIGHT = HID_D,
  parameter logic [7:0] KEY_FIRE = HID_SPACE
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_clk,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_press,
  output logic [7:0] cur_code,
  output logic       left_held,
  output logic       right_held,
  output logic       fire_held,
  output logic       frame_tick,
  output logic       frame_left,
  output logic       frame_right,
  output logic       frame_fire,
  output logic       overflow
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  evt_state_e st_q, st_d;
  logic [7:0] k_q, cand_q, cur_q, cur_d, old_q, old_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] sync_q, sticky_q, sticky_d, frame_q, frame_d, held, pv;
  logic tick_q, ovf_q, ovf_d, commit, push, pop, full, empty;
  key_evt_t push_evt, head;
  always_comb begin
    held = {cur_q == KEY_FIRE, cur_q == KEY_RIGHT, cur_q == KEY_LEFT};
    commit = st_q == IDLE && cnt_q == CMAX && cand_q != cur_q;
    cnt_d = k_q != cand_q ? CW'(1) : cnt_q == CMAX ? cnt_q : cnt_q + CW'(1);
    cur_d = commit ? cand_q : cur_q;
    old_d = commit ? cur_q : old_q;
    st_d = st_q == EMIT_REL ? (|cur_q ? EMIT_PRESS : IDLE) : st_q == EMIT_PRESS ? IDLE : !commit ? IDLE : |cur_q ? EMIT_REL : EMIT_PRESS;
    push = st_q != IDLE;
    push_evt.code = st_q == EMIT_REL ? old_q : cur_q;
    push_evt.press = st_q == EMIT_PRESS;
    pv = push_evt.press ? {push_evt.code == KEY_FIRE, push_evt.code == KEY_RIGHT, push_evt.code == KEY_LEFT} : 3'b000;
    pop = !empty && evt_ready;
    ovf_d = ovf_q | (push && full && !pop);
    sticky_d = tick_q ? 3'b000 : sticky_q | pv;
    frame_d = tick_q ? held | sticky_q | pv : frame_q;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      st_q <= IDLE;
      k_q <= '0;
      cand_q <= '0;
      cnt_q <= '0;
      cur_q <= '0;
      old_q <= '0;
      sync_q <= '0;
      tick_q <= 1'b0;
      sticky_q <= '0;
      frame_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      st_q <= st_d;
      k_q <= keycode;
      cand_q <= k_q;
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      old_q <= old_d;
      sync_q <= {sync_q[1:0], frame_clk};
      tick_q <= sync_q[1] & ~sync_q[2];
      sticky_q <= sticky_d;
      frame_q <= frame_d;
      ovf_q <= ovf_d;
    end
  end
  evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clk),
    .rst_n(Reset_n),
    .push(push),
    .pop(pop),
    .din(push_evt),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign evt_valid = !empty;
  assign evt_code = head.code;
  assign evt_press = head.press;
  assign cur_code = cur_q;
  assign {fire_held, right_held, left_held} = held;
  assign frame_tick = tick_q;
  assign {frame_fire, frame_right, frame_left} = frame_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_keycode_event_decoder.sv
// tb_keycode_event_decoder: table, directed and random checks of keycode_event_decoder against a sample-history reference model
module tb_keycode_event_decoder;
  import keycode_pkg::*;
  localparam int S = 4;
  localparam int D = 4;
  localparam logic [7:0] KL = 8'h04;
  localparam logic [7:0] KR = 8'h07;
  localparam logic [7:0] KF = 8'h2C;
  logic Clk = 0;
  logic Reset_n = 0;
  logic frame_clk = 0;
  logic evt_ready = 0;
  logic [7:0] keycode = 0;
  logic evt_valid, evt_press, left_held, right_held, fire_held;
  logic frame_tick, frame_left, frame_right, frame_fire, overflow;
  logic [7:0] evt_code, cur_code;
  keycode_event_decoder #(
    .STABLE_CYCLES(S), .FIFO_DEPTH(D), .KEY_LEFT(KL), .KEY_RIGHT(KR), .KEY_FIRE(KF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_clk(frame_clk), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_press(evt_press), .cur_code(cur_code),
    .left_held(left_held), .right_held(right_held), .fire_held(fire_held), .frame_tick(frame_tick),
    .frame_left(frame_left), .frame_right(frame_right), .frame_fire(frame_fire), .overflow(overflow)
  );
  always #5 Clk = ~Clk;
  int ncmp = 0;
  int nfail = 0;
  logic [7:0] kh [0:8191];
  logic fh [0:8191];
  int n = 8;
  int last_rst = 8;
  logic [7:0] m_cur = 0;
  logic [2:0] m_st = 0;
  logic [2:0] m_fr = 0;
  logic m_tick = 0;
  logic m_ovf = 0;
  key_evt_t pend[$];
  key_evt_t q[$];
  typedef struct {
    logic [7:0] kc;
    int         hold;
    logic [7:0] cur;
    logic [2:0] hl;
  } vec_t;
  vec_t tbl [11];
  function automatic logic [2:0] keys(input logic [7:0] c);
    return {c == KF, c == KR, c == KL};
  endfunction
  function automatic key_evt_t mk(input logic [7:0] c, input logic p);
    key_evt_t e;
    e.code = c;
    e.press = p;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 'h%0h, want 'h%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic model_edge();
    logic [7:0] nv;
    logic [2:0] hld, pv;
    logic pop, push, ok;
    key_evt_t ev;
    n++;
    if (n > 8180) begin
      $display("FAIL model_range: got %0d, want < 8180", n);
      $fatal(1, "history exhausted");
    end
    if (!Reset_n) begin
      kh[n] = 0;
      fh[n] = 0;
      fh[n-1] = 0;
      fh[n-2] = 0;
      last_rst = n;
      m_cur = 0;
      m_st = 0;
      m_fr = 0;
      m_tick = 0;
      m_ovf = 0;
      pend.delete();
      q.delete();
    end else begin
      kh[n] = keycode;
      fh[n] = frame_clk;
      hld = keys(m_cur);
      pop = q.size() > 0 && evt_ready;
      push = 0;
      pv = 0;
      ev = mk(8'h00, 1'b0);
      if (pend.size() > 0) begin
        ev = pend.pop_front();
        push = 1;
        if (ev.press) pv = keys(ev.code);
      end else if (n - S - 1 >= last_rst && kh[n-2] != m_cur) begin
        nv = kh[n-2];
        ok = 1;
        for (int i = n - S - 1; i < n - 2; i++) if (kh[i] != nv) ok = 0;
        if (ok) begin
          if (m_cur != 0) pend.push_back(mk(m_cur, 1'b0));
          if (nv != 0) pend.push_back(mk(nv, 1'b1));
          m_cur = nv;
        end
      end
      if (m_tick) begin
        m_fr = hld | m_st | pv;
        m_st = 0;
      end else m_st = m_st | pv;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < D) q.push_back(ev);
        else m_ovf = 1;
      end
      m_tick = fh[n-2] & ~fh[n-3];
    end
  endtask
  task automatic compare_all();
    key_evt_t h;
    h = mk(8'h00, 1'b0);
    if (q.size() > 0) h = q[0];
    chk("evt_valid", evt_valid, q.size() > 0);
    chk("evt_code", evt_code, h.code);
    chk("evt_press", evt_press, h.press);
    chk("cur_code", cur_code, m_cur);
    chk("held", {fire_held, right_held, left_held}, keys(m_cur));
    chk("frame_tick", frame_tick, m_tick);
    chk("frame_bits", {frame_fire, frame_right, frame_left}, m_fr);
    chk("overflow", overflow, m_ovf);
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge Clk);
      #1;
      model_edge();
      compare_all();
    end
  endtask
  initial begin
    logic p;
    int r;
    for (int i = 0; i < 8192; i++) begin
      kh[i] = 0;
      fh[i] = 0;
    end
    tbl[0] = '{KL, 8, KL, 3'b001};
    tbl[1] = '{8'h00, 8, 8'h00, 3'b000};
    tbl[2] = '{KR, 8, KR, 3'b010};
    tbl[3] = '{KF, 8, KF, 3'b100};
    tbl[4] = '{KL, 2, KF, 3'b100};
    tbl[5] = '{KF, 8, KF, 3'b100};
    tbl[6] = '{KR, 8, KR, 3'b010};
    tbl[7] = '{8'h00, 8, 8'h00, 3'b000};
    tbl[8] = '{8'h15, 8, 8'h15, 3'b000};
    tbl[9] = '{KR, 3, 8'h15, 3'b000};
    tbl[10] = '{8'h00, 8, 8'h00, 3'b000};
    Reset_n = 0;
    step(2);
    chk("rst_valid", evt_valid, 0);
    chk("rst_cur", cur_code, 0);
    Reset_n = 1;
    step(8);
    keycode = KL;
    step(3);
    keycode = 0;
    step(10);
    chk("glitch_cur", cur_code, 0);
    chk("glitch_valid", evt_valid, 0);
    keycode = KL;
    step(5);
    chk("t1_cur_e5", cur_code, 0);
    step(1);
    chk("t1_cur_e6", cur_code, KL);
    chk("t1_valid_e6", evt_valid, 0);
    chk("t1_left", left_held, 1);
    step(1);
    chk("t1_valid_e7", evt_valid, 1);
    chk("t1_head", {evt_code, evt_press}, {KL, 1'b1});
    evt_ready = 1;
    step(1);
    chk("t1_drained", evt_valid, 0);
    evt_ready = 0;
    keycode = KR;
    step(12);
    chk("t3_head_rel", {evt_code, evt_press}, {KL, 1'b0});
    chk("t3_right", right_held, 1);
    chk("t3_left", left_held, 0);
    evt_ready = 1;
    step(1);
    chk("t3_head_press", {evt_code, evt_press}, {KR, 1'b1});
    step(1);
    chk("t3_drained", evt_valid, 0);
    keycode = 0;
    step(12);
    chk("t4_ovf_before", overflow, 0);
    evt_ready = 0;
    for (int i = 0; i < 3; i++) begin
      keycode = KL;
      step(8);
      keycode = 0;
      step(8);
    end
    chk("t4_ovf", overflow, 1);
    evt_ready = 1;
    for (int i = 0; i < 4; i++) begin
      p = (i % 2 == 0);
      chk("t4_drain", {evt_valid, evt_code, evt_press}, {1'b1, KL, p});
      step(1);
    end
    chk("t4_empty", evt_valid, 0);
    frame_clk = 1;
    step(6);
    frame_clk = 0;
    step(4);
    keycode = KF;
    step(10);
    keycode = 0;
    step(12);
    chk("t5_fire_pre", frame_fire, 0);
    frame_clk = 1;
    step(3);
    chk("t5_tick", frame_tick, 1);
    step(1);
    chk("t5_fire", frame_fire, 1);
    chk("t5_tick_off", frame_tick, 0);
    frame_clk = 0;
    step(5);
    frame_clk = 1;
    step(4);
    chk("t5_fire_clr", frame_fire, 0);
    frame_clk = 0;
    evt_ready = 0;
    keycode = KL;
    step(8);
    keycode = KR;
    step(10);
    evt_ready = 1;
    step(1);
    evt_ready = 0;
    chk("t6_pre_valid", evt_valid, 1);
    Reset_n = 0;
    step(1);
    chk("t6_rst_evt", {evt_valid, evt_code, evt_press}, 0);
    chk("t6_rst_cur", cur_code, 0);
    chk("t6_rst_held", {fire_held, right_held, left_held}, 0);
    chk("t6_rst_frame", {frame_tick, frame_fire, frame_right, frame_left}, 0);
    chk("t6_rst_ovf", overflow, 0);
    Reset_n = 1;
    step(12);
    chk("t6_head", {evt_valid, evt_code, evt_press}, {1'b1, KR, 1'b1});
    evt_ready = 1;
    step(1);
    chk("t6_single", evt_valid, 0);
    step(10);
    chk("t6_single_late", evt_valid, 0);
    for (int i = 0; i < 11; i++) begin
      keycode = tbl[i].kc;
      step(tbl[i].hold);
      chk("tbl_cur", cur_code, tbl[i].cur);
      chk("tbl_held", {fire_held, right_held, left_held}, tbl[i].hl);
    end
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      keycode = r < 3 ? 8'h00 : r < 5 ? KL : r < 7 ? KR : r == 7 ? KF : 8'($urandom);
      evt_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      if ($urandom_range(0, 40) == 0) Reset_n = 0;
      step($urandom_range(1, 8));
      Reset_n = 1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/keycode_event_decoder.md
Name: keycode_event_decoder

Overview:
- Receives the 8-bit USB HID keycode written by the NIOS PIO (`keycode_export`), which carries one key at a time.
- Filters glitches and turns level changes into discrete press/release events, delivered through a small valid/ready FIFO.
- Also provides per-frame latched control bits (left/right/fire), sampled on the VGA vertical sync, so jumplogic never misses a tap shorter than one frame.
- Sits between the SoC keycode export and jumplogic/color_mapper.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a keycode change is committed (>=1).
- FIFO_DEPTH, 4, event FIFO entries (power of two, >=2).
- KEY_LEFT, 8'h04, HID code for A (move left).
- KEY_RIGHT, 8'h07, HID code for D (move right).
- KEY_FIRE, 8'h2C, HID code for space (cannon).

Ports:
- Clk  in  1  MAX10_CLK1_50 domain clock.
- Reset_n  in  1  synchronous, active-low reset.
- keycode  in  8  raw keycode from SoC PIO; 8'h00 = no key.
- frame_clk  in  1  VGA_VS, asynchronous to Clk.
- evt_ready  in  1  consumer accepts the head event this cycle.
- evt_valid  out  1  FIFO non-empty.
- evt_code  out  8  keycode of the head event.
- evt_press  out  1  1 = press, 0 = release.
- cur_code  out  8  committed (filtered) keycode.
- left_held, right_held, fire_held  out  1 each  cur_code equals the respective KEY_* code.
- frame_tick  out  1  one-cycle pulse per frame_clk rising edge.
- frame_left, frame_right, frame_fire  out  1 each  per-frame latched controls.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (Reset_n=0 at an edge): every output 0, FIFO emptied, filter candidate=0, count=0, sticky bits cleared.
  - No release event is generated for a key held across reset.
  - Reset takes priority over all other activity.
- Stability filter:
  - k_q registers keycode.
  - If k_q != cand: cand<=k_q and cnt<=1.
  - Otherwise cnt saturates at STABLE_CYCLES.
  - Commit when cnt==STABLE_CYCLES and cand!=cur_code.
  - Net effect: cur_code changes STABLE_CYCLES+2 edges after keycode first presents a new stable value.
  - Changes shorter than STABLE_CYCLES samples are ignored entirely.
- Event FSM, states IDLE, EMIT_REL, EMIT_PRESS:
  - IDLE, on commit of new code N with old code O:
    - O!=0: go to EMIT_REL.
    - O==0: go to EMIT_PRESS.
    - cur_code<=N in the same cycle.
  - EMIT_REL: push {O, release}. Then N!=0 goes to EMIT_PRESS, else IDLE.
  - EMIT_PRESS: push {N, press}, then go to IDLE.
  - The FSM takes one cycle per push. The filter is not re-armed until the FSM returns to IDLE; a commit pending in a non-IDLE state waits.
- FIFO:
  - Registered: evt_valid rises the edge after the push.
  - Pop occurs when evt_valid && evt_ready.
  - Simultaneous push and pop when full is allowed; the push succeeds.
  - Push when full and no pop: the event is dropped and overflow<=1, cleared only by reset.
  - *_held outputs follow cur_code regardless of FIFO state.
- Frame latch:
  - frame_clk passes through a 2-flop synchronizer plus rising-edge detect; frame_tick appears 3 edges after the frame_clk rise.
  - Sticky press bits set on each press event for left/right/fire, whether or not the push succeeds.
  - On frame_tick: frame_x <= x_held | sticky_x, then sticky_x <= 0.
  - A press on the tick cycle itself is included in that latch and not carried forward.
- Widths: cnt is $clog2(STABLE_CYCLES+1) bits. FIFO pointers are $clog2(FIFO_DEPTH)+1 bits (wrap bit distinguishes full from empty).

Decomposition:
- Package keycode_pkg:
  - HID constants (KEY_LEFT/RIGHT/FIRE defaults).
  - typedef struct packed {logic [7:0] code; logic press;} key_evt_t.
  - enum for the FSM states.
- One sub-module, evt_fifo: parameterised synchronous FIFO of key_evt_t, with push/pop/full/empty and active-low sync reset.

Test Plan:
- STABLE_CYCLES=4: keycode 00→04 held → cur_code=04 at edge 6. Next edge evt_valid=1, {04, press}, left_held=1.
- Keycode 04 for 3 cycles, then 00 → no event, cur_code stays 00.
- Held 04, then direct switch to 07 → events {04, release} then {07, press}; right_held=1, left_held=0.
- evt_ready=0, 6 alternating 04/00 commits with FIFO_DEPTH=4 → 4 events retained in order, overflow=1. Draining yields the first four events exactly.
- Tap 2C lasting 10 cycles between two frame_clk rises → frame_fire=1 after next frame_tick, 0 after the following one.
- Reset_n=0 while 07 is held and FIFO has 2 entries → all outputs 0 next edge. After release of reset with keycode still 07 → single {07, press}.
